puf_eval_ctrl: RTL and testbench

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

---
 rtl/puf_pkg.sv | 22 ++
 rtl/puf_win_timer.sv | 28 ++
 rtl/puf_eval_ctrl.sv | 171 +++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF evaluation controller: FSM states,
// select/count widths and the 3-way majority helper.
package puf_pkg;

   localparam int SEL_W = 5;
   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      SETTLE,
      COMPARE,
      NEXT,
      DONE
   } puf_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/puf_win_timer.sv
// Loadable down-counter for the RUN window and SETTLE gap; zero is raised
// while the count is exhausted.
module puf_win_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/puf_eval_ctrl.sv
// RO-PUF evaluation sequencer: clears, runs and compares two oscillator banks
// per response bit. Define PUF_MAJORITY_EN for 3-pass majority voting per bit.
module puf_eval_ctrl
   import puf_pkg::*;
#(
   parameter int RESP_BITS  = 8,
   parameter int WIN_W      = 16,
   parameter int SETTLE_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [SEL_W-1:0]     challenge,
   input  logic [WIN_W-1:0]     win_len,
   input  logic [CNT_W-1:0]     cnt_a,
   input  logic [CNT_W-1:0]     cnt_b,
   output logic [SEL_W-1:0]     ro_sel,
   output logic                 ro_en,
   output logic                 cnt_clr,
   output logic                 busy,
   output logic                 resp_valid,
   output logic [RESP_BITS-1:0] response,
   output logic                 tie_flag
);

   localparam int IDX_W = 4;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(RESP_BITS - 1);
   localparam logic [WIN_W-1:0] SETTLE_LOAD = (SETTLE_CYC > 0) ? WIN_W'(SETTLE_CYC - 1) : '0;

   puf_state_t       state;
   logic [WIN_W-1:0] win_reg;
   logic [IDX_W-1:0] bit_idx;
   logic             tmr_load;
   logic             tmr_dec;
   logic [WIN_W-1:0] tmr_val;
   logic             tmr_zero;
   logic             cmp_gt;
   logic             cmp_eq;

`ifdef PUF_MAJORITY_EN
   logic [1:0] pass_idx;
   logic [1:0] votes;
`endif

   assign cmp_gt = (cnt_a > cnt_b);
   assign cmp_eq = (cnt_a == cnt_b);

   // A zero window still runs the oscillators for one cycle, so load max(win,1)-1.
   always_comb begin
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = SETTLE_LOAD;
      case (state)
         CLEAR: begin
            tmr_load = 1'b1;
            tmr_val  = (win_reg == '0) ? '0 : win_reg - WIN_W'(1);
         end
         RUN: begin
            if (tmr_zero) tmr_load = 1'b1;
            else          tmr_dec  = 1'b1;
         end
         SETTLE: begin
            if (!tmr_zero) tmr_dec = 1'b1;
         end
         default: ;
      endcase
   end

   puf_win_timer #(.W(WIN_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         win_reg    <= '0;
         bit_idx    <= '0;
         ro_sel     <= '0;
         ro_en      <= 1'b0;
         cnt_clr    <= 1'b0;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         response   <= '0;
         tie_flag   <= 1'b0;
`ifdef PUF_MAJORITY_EN
         pass_idx   <= '0;
         votes      <= '0;
`endif
      end else begin
         cnt_clr    <= 1'b0;
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ro_sel   <= challenge;
                  win_reg  <= win_len;
                  response <= '0;
                  bit_idx  <= '0;
                  tie_flag <= 1'b0;
`ifdef PUF_MAJORITY_EN
                  pass_idx <= '0;
                  votes    <= '0;
`endif
                  cnt_clr  <= 1'b1;
                  busy     <= 1'b1;
                  state    <= CLEAR;
               end
            end
            CLEAR: begin
               ro_en <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               if (tmr_zero) begin
                  ro_en <= 1'b0;
                  state <= (SETTLE_CYC > 0) ? SETTLE : COMPARE;
               end
            end
            SETTLE: begin
               if (tmr_zero) state <= COMPARE;
            end
            // Response bits are OR-ed in; response was cleared on start.
            COMPARE: begin
               if (cmp_eq) tie_flag <= 1'b1;
`ifdef PUF_MAJORITY_EN
               if (pass_idx == 2'd2) begin
                  response <= response | (RESP_BITS'(maj3(votes[0], votes[1], cmp_gt)) << bit_idx);
                  pass_idx <= '0;
                  votes    <= '0;
                  state    <= NEXT;
               end else begin
                  votes[pass_idx[0]] <= cmp_gt;
                  pass_idx <= pass_idx + 2'd1;
                  cnt_clr  <= 1'b1;
                  state    <= CLEAR;
               end
`else
               response <= response | (RESP_BITS'(cmp_gt) << bit_idx);
               state    <= NEXT;
`endif
            end
            NEXT: begin
               if (bit_idx == LAST_IDX) begin
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  bit_idx <= bit_idx + IDX_W'(1);
                  ro_sel  <= ro_sel + SEL_W'(1);
                  cnt_clr <= 1'b1;
                  state   <= CLEAR;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               ro_en <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed self-checking bench for puf_eval_ctrl with a behavioural
// oscillator-count source keyed on ro_sel and measurement pass.
module tb_puf_eval_ctrl;
   import puf_pkg::*;

`ifdef PUF_MAJORITY_EN
   localparam int PASSES = 3;
`else
   localparam int PASSES = 1;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [SEL_W-1:0] challenge = '0;
   logic [15:0]      win_len = '0;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic [SEL_W-1:0] ro_sel;
   logic             ro_en;
   logic             cnt_clr;
   logic             busy;
   logic             resp_valid;
   logic [7:0]       response;
   logic             tie_flag;

   int errors = 0;
   int checks = 0;
   int mode = 0;
   int tieSel = -1;
   int clrPulses = 0;
   int enTotal = 0;
   int runLen = 0;
   int minRun = 0;
   int maxRun = 0;
   int validCount = 0;
   logic prevEn = 1'b0;
   logic [SEL_W-1:0] selLog [64];

   puf_eval_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .challenge  (challenge),
      .win_len    (win_len),
      .cnt_a      (cnt_a),
      .cnt_b      (cnt_b),
      .ro_sel     (ro_sel),
      .ro_en      (ro_en),
      .cnt_clr    (cnt_clr),
      .busy       (busy),
      .resp_valid (resp_valid),
      .response   (response),
      .tie_flag   (tie_flag)
   );

   always #5 clk = ~clk;

   // Count source: mode 0 odd-select wins, mode 1 adds a tie, mode 2 varies by pass.
   always_comb begin
      cnt_a = 16'd100;
      cnt_b = 16'd200;
      if (mode == 2) begin
         if (((clrPulses - 1) % 3) != 1) begin
            cnt_a = 16'd300;
            cnt_b = 16'd250;
         end
      end else if ((mode == 1) && (int'(ro_sel) == tieSel)) begin
         cnt_a = 16'h1234;
         cnt_b = 16'h1234;
      end else if (ro_sel[0]) begin
         cnt_a = 16'd200;
         cnt_b = 16'd100;
      end
   end

   always @(negedge clk) begin
      if (cnt_clr) begin
         if (clrPulses < 64) selLog[clrPulses] = ro_sel;
         clrPulses++;
      end
      if (ro_en) begin
         enTotal++;
         runLen++;
      end else if (prevEn) begin
         if (runLen < minRun) minRun = runLen;
         if (runLen > maxRun) maxRun = runLen;
         runLen = 0;
      end
      prevEn = ro_en;
      if (resp_valid) validCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic applyStimulus(input logic [SEL_W-1:0] ch, input logic [15:0] win, input int md, input int tsel);
      clrPulses  = 0;
      enTotal    = 0;
      runLen     = 0;
      minRun     = 1000000;
      maxRun     = 0;
      validCount = 0;
      mode       = md;
      tieSel     = tsel;
      challenge  = ch;
      win_len    = win;
      start      = 1'b1;
      tick(1);
      start      = 1'b0;
   endtask

   task automatic waitDone(input string tag);
      int n = 0;
      while (!resp_valid && n < 6000) begin
         tick(1);
         n++;
      end
      checkOutput({tag, "_done"}, {31'd0, resp_valid}, 32'd1);
   endtask

   initial begin
      $display("[TB] start");
      #23;
      checkOutput("rst_ro_sel", {27'd0, ro_sel}, 32'd0);
      checkOutput("rst_ro_en", {31'd0, ro_en}, 32'd0);
      checkOutput("rst_cnt_clr", {31'd0, cnt_clr}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_resp", {24'd0, response}, 32'd0);
      checkOutput("rst_tie", {31'd0, tie_flag}, 32'd0);
      rst_n = 1'b1;
      tick(2);

      // challenge 5, window 100: odd selects 5,7,9,11 win -> 0x55
      applyStimulus(5'd5, 16'd100, 0, -1);
      checkOutput("a_busy", {31'd0, busy}, 32'd1);
      waitDone("a");
      checkOutput("a_resp", {24'd0, response}, 32'h55);
      checkOutput("a_tie", {31'd0, tie_flag}, 32'd0);
      checkOutput("a_sel_first", {27'd0, selLog[0]}, 32'd5);
      checkOutput("a_sel_last", {27'd0, selLog[7 * PASSES]}, 32'd12);
      checkOutput("a_clr_pulses", clrPulses, 8 * PASSES);
      checkOutput("a_en_total", enTotal, 800 * PASSES);
      checkOutput("a_min_run", minRun, 100);
      checkOutput("a_max_run", maxRun, 100);
      tick(3);
      checkOutput("a_valid_cnt", validCount, 1);
      checkOutput("a_idle", {31'd0, busy}, 32'd0);

      // challenge 30 wraps: 30,31,0,1,... odd winners 31,1,3,5 -> 0xAA
      applyStimulus(5'd30, 16'd3, 0, -1);
      waitDone("b");
      checkOutput("b_sel0", {27'd0, selLog[0]}, 32'd30);
      checkOutput("b_sel1", {27'd0, selLog[PASSES]}, 32'd31);
      checkOutput("b_sel2", {27'd0, selLog[2 * PASSES]}, 32'd0);
      checkOutput("b_sel3", {27'd0, selLog[3 * PASSES]}, 32'd1);
      checkOutput("b_resp", {24'd0, response}, 32'hAA);
      checkOutput("b_min_run", minRun, 3);
      tick(3);

      // equal counts on bit 2 (ro_sel 2): bit stays 0, tie sticks after DONE
      applyStimulus(5'd0, 16'd2, 1, 2);
      waitDone("c");
      tick(4);
      checkOutput("c_resp", {24'd0, response}, 32'hAA);
      checkOutput("c_resp_bit2", {31'd0, response[2]}, 32'd0);
      checkOutput("c_tie", {31'd0, tie_flag}, 32'd1);
      checkOutput("c_busy", {31'd0, busy}, 32'd0);

      // zero window gives one enable cycle; a start while busy is ignored
      applyStimulus(5'd10, 16'd0, 0, -1);
      tick(5);
      challenge = 5'd20;
      start     = 1'b1;
      tick(1);
      start     = 1'b0;
      waitDone("d");
      tick(10);
      checkOutput("d_resp", {24'd0, response}, 32'hAA);
      checkOutput("d_sel0", {27'd0, selLog[0]}, 32'd10);
      checkOutput("d_min_run", minRun, 1);
      checkOutput("d_max_run", maxRun, 1);
      checkOutput("d_en_total", enTotal, 8 * PASSES);
      checkOutput("d_valid_cnt", validCount, 1);
      checkOutput("d_busy", {31'd0, busy}, 32'd0);

`ifdef PUF_MAJORITY_EN
      // passes a>b, a<b, a>b on every bit -> all ones, three clears per bit
      applyStimulus(5'd0, 16'd2, 2, -1);
      waitDone("e");
      checkOutput("e_resp", {24'd0, response}, 32'hFF);
      checkOutput("e_clr_pulses", clrPulses, 24);
      checkOutput("e_sel_pass2", {27'd0, selLog[2]}, 32'd0);
      tick(3);
`endif

      // reset during RUN of bit 3: everything drops at once, nothing reported
      begin
         int n = 0;
         applyStimulus(5'd0, 16'd50, 0, -1);
         while (!((clrPulses == 3 * PASSES + 1) && ro_en) && n < 3000) begin
            tick(1);
            n++;
         end
         tick(10);
         checkOutput("r_in_run", {31'd0, ro_en}, 32'd1);
         checkOutput("r_pre_resp", {24'd0, response}, 32'h02);
         rst_n = 1'b0;
         #1;
         checkOutput("r_ro_en", {31'd0, ro_en}, 32'd0);
         checkOutput("r_busy", {31'd0, busy}, 32'd0);
         checkOutput("r_resp", {24'd0, response}, 32'd0);
         checkOutput("r_sel", {27'd0, ro_sel}, 32'd0);
         tick(2);
         rst_n = 1'b1;
         tick(20);
         checkOutput("r_valid_cnt", validCount, 0);
         checkOutput("r_idle", {31'd0, busy}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
